// File: rtl/guardian_pkg.sv
// Shared types and constants for the Guardian authentication sequencer.
package guardian_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EE_READ,
        ST_KEY_CHECK,
        ST_NFC_READ,
        ST_VERDICT,
        ST_UNLOCK,
        ST_FAULT,
        ST_DONE
    } state_t;

    localparam logic [7:0] OP_EE_READ     = 8'h03;
    localparam logic [7:0] OP_NFC_FIFO_RD = 8'h92;
    localparam logic [7:0] OP_BURST_END   = 8'h00;

    localparam int unsigned KEY_BYTES = 16;

    // Bytes per transaction: opcode + address + key, and 16 FIFO reads + terminator.
    localparam logic [4:0] EE_XFER_BYTES  = 5'd18;
    localparam logic [4:0] NFC_XFER_BYTES = 5'd17;

    typedef logic [8*KEY_BYTES-1:0] key_t;

    // Byte idx of a key, byte 0 in the most significant position.
    function automatic logic [7:0] key_byte(input key_t key, input logic [3:0] idx);
        return key[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/guardian_main_core_spi_byte_master.sv
// Mode-0, MSB-first SPI byte engine; a start on the done cycle chains bytes back-to-back.
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [3:0]    phase;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          tick;

    assign tick    = busy && (div_cnt == DW'(CLK_DIV - 1));
    assign done    = tick && (phase == 4'hF);
    assign rx_byte = rx_sh;
    assign mosi    = tx_sh[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            div_cnt <= '0;
            phase   <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sclk    <= 1'b0;
        end else if (start && (!busy || done)) begin
            busy    <= 1'b1;
            div_cnt <= '0;
            phase   <= '0;
            tx_sh   <= tx_byte;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= phase + 4'd1;
            // Even phases end on a rising edge (sample), odd phases on a falling edge (shift).
            if (!phase[0]) begin
                sclk  <= 1'b1;
                rx_sh <= {rx_sh[6:0], miso};
            end else begin
                sclk  <= 1'b0;
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (done) begin
                busy <= 1'b0;
            end
        end else if (busy) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/guardian_main_core.sv
// Guardian door-lock sequencer: reads the PSK from EEPROM, reads the card response
// from the MFRC522 FIFO, compares them and drives the door or raises a fault.
module guardian_main_core
    import guardian_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 2,
    parameter logic [7:0]  PSK_ADDR      = 8'h00,
    parameter int unsigned UNLOCK_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic nfc_spi_cs_n,
    output logic nfc_spi_sclk,
    output logic nfc_spi_mosi,
    input  logic nfc_spi_miso,
    output logic eeprom_spi_cs_n,
    output logic eeprom_spi_sclk,
    output logic eeprom_spi_mosi,
    input  logic eeprom_spi_miso,
    output logic door_unlock,
    output logic status_unlock,
    output logic status_fault,
    output logic status_busy,
    input  logic start_auth_btn
);

    localparam int unsigned TW = $clog2(CLK_DIV + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CYCLES + 1);

    state_t        state;
    state_t        state_nx;
    logic [1:0]    sync_q;
    logic          sync_prev;
    logic          start_edge;
    logic          accept;
    logic [4:0]    byte_cnt;
    logic [TW-1:0] tail_cnt;
    key_t          psk;
    logic          mismatch;
    logic [UW-1:0] unlock_cnt;
    logic          in_ee;
    logic          in_nfc;
    logic          in_xfer;
    logic          xfer_end;
    logic          cs_active;
    logic [4:0]    xfer_len;
    logic [3:0]    rsp_idx;
    logic          spi_start;
    logic          spi_done;
    logic          spi_busy;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso;
    logic [7:0]    spi_tx;
    logic [7:0]    spi_rx;

    assign start_edge = sync_q[1] & ~sync_prev;
    assign accept     = start_edge && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_ee      = (state == ST_EE_READ);
    assign in_nfc     = (state == ST_NFC_READ);
    assign in_xfer    = in_ee || in_nfc;
    assign xfer_len   = in_ee ? EE_XFER_BYTES : NFC_XFER_BYTES;
    // byte_cnt counts bytes started, so at a done it is one past the finished byte.
    assign spi_start  = in_xfer && (((byte_cnt == '0) && !spi_busy) ||
                                    (spi_done && (byte_cnt != xfer_len)));
    assign xfer_end   = in_xfer && (tail_cnt == TW'(1));
    assign cs_active  = spi_busy || (tail_cnt != '0);
    assign rsp_idx    = 4'(byte_cnt - 5'd2);
    assign spi_miso   = in_nfc ? nfc_spi_miso : eeprom_spi_miso;

    always_comb begin
        spi_tx = OP_BURST_END;
        if (in_ee) begin
            if (byte_cnt == 5'd0) begin
                spi_tx = OP_EE_READ;
            end else if (byte_cnt == 5'd1) begin
                spi_tx = PSK_ADDR;
            end
        end else if (in_nfc && (byte_cnt < 5'(KEY_BYTES))) begin
            spi_tx = OP_NFC_FIFO_RD;
        end
    end

    spi_byte_master #(
        .CLK_DIV(CLK_DIV)
    ) u_spi (
        .clk    (clk),
        .rst    (rst),
        .start  (spi_start),
        .tx_byte(spi_tx),
        .rx_byte(spi_rx),
        .done   (spi_done),
        .busy   (spi_busy),
        .sclk   (spi_sclk),
        .mosi   (spi_mosi),
        .miso   (spi_miso)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (accept)   state_nx = ST_EE_READ;
            ST_EE_READ:       if (xfer_end) state_nx = ST_KEY_CHECK;
            ST_KEY_CHECK:     state_nx = ((psk == '0) || (psk == '1)) ? ST_FAULT : ST_NFC_READ;
            ST_NFC_READ:      if (xfer_end) state_nx = ST_VERDICT;
            ST_VERDICT:       state_nx = mismatch ? ST_FAULT : ST_UNLOCK;
            ST_UNLOCK:        if (unlock_cnt == UW'(UNLOCK_CYCLES - 1)) state_nx = ST_DONE;
            ST_FAULT:         state_nx = ST_DONE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        eeprom_spi_cs_n = 1'b1;
        eeprom_spi_sclk = 1'b0;
        eeprom_spi_mosi = 1'b0;
        nfc_spi_cs_n    = 1'b1;
        nfc_spi_sclk    = 1'b0;
        nfc_spi_mosi    = 1'b0;
        if (in_ee) begin
            eeprom_spi_cs_n = ~cs_active;
            eeprom_spi_sclk = spi_sclk;
            eeprom_spi_mosi = spi_mosi;
        end
        if (in_nfc) begin
            nfc_spi_cs_n = ~cs_active;
            nfc_spi_sclk = spi_sclk;
            nfc_spi_mosi = spi_mosi;
        end
        door_unlock = (state == ST_UNLOCK);
        status_busy = in_xfer || (state == ST_KEY_CHECK) || (state == ST_VERDICT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= '0;
            sync_prev     <= 1'b0;
            byte_cnt      <= '0;
            tail_cnt      <= '0;
            psk           <= '0;
            mismatch      <= 1'b0;
            unlock_cnt    <= '0;
            status_unlock <= 1'b0;
            status_fault  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], start_auth_btn};
            sync_prev <= sync_q[1];

            if (!in_xfer) begin
                byte_cnt <= '0;
                tail_cnt <= '0;
            end else begin
                if (spi_start) begin
                    byte_cnt <= byte_cnt + 5'd1;
                end
                // CS is held for CLK_DIV cycles after the final falling SCLK edge.
                if (spi_done && (byte_cnt == xfer_len)) begin
                    tail_cnt <= TW'(CLK_DIV);
                end else if (tail_cnt != '0) begin
                    tail_cnt <= tail_cnt - 1'b1;
                end
            end

            if (accept) begin
                status_unlock <= 1'b0;
                status_fault  <= 1'b0;
                mismatch      <= 1'b0;
                psk           <= '0;
            end

            if (in_ee && spi_done && (byte_cnt >= 5'd3)) begin
                psk <= {psk[8*KEY_BYTES-9:0], spi_rx};
            end

            if (in_nfc && spi_done && (byte_cnt >= 5'd2) && (spi_rx != key_byte(psk, rsp_idx))) begin
                mismatch <= 1'b1;
            end

            unlock_cnt <= (state == ST_UNLOCK) ? unlock_cnt + 1'b1 : '0;

            if (state_nx == ST_FAULT) begin
                status_fault <= 1'b1;
            end
            if (state_nx == ST_UNLOCK) begin
                status_unlock <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_guardian_main_core.sv
// Scoreboard bench for guardian_main_core with bit-level EEPROM and MFRC522 SPI models.
`timescale 1ns/1ps
module tb_guardian_main_core;

    localparam int unsigned CLK_DIV       = 2;
    localparam int unsigned UNLOCK_CYCLES = 100;
    localparam logic [127:0] PSK          = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [9:0]  RESET_OUTS    = 10'b11_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_auth_btn = 1'b0;
    logic nfc_spi_cs_n, nfc_spi_sclk, nfc_spi_mosi, nfc_spi_miso;
    logic eeprom_spi_cs_n, eeprom_spi_sclk, eeprom_spi_mosi, eeprom_spi_miso;
    logic door_unlock, status_unlock, status_fault, status_busy;
    logic [9:0] outs;

    always #5 clk = ~clk;

    guardian_main_core #(
        .CLK_DIV      (CLK_DIV),
        .PSK_ADDR     (8'h00),
        .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .nfc_spi_cs_n   (nfc_spi_cs_n),
        .nfc_spi_sclk   (nfc_spi_sclk),
        .nfc_spi_mosi   (nfc_spi_mosi),
        .nfc_spi_miso   (nfc_spi_miso),
        .eeprom_spi_cs_n(eeprom_spi_cs_n),
        .eeprom_spi_sclk(eeprom_spi_sclk),
        .eeprom_spi_mosi(eeprom_spi_mosi),
        .eeprom_spi_miso(eeprom_spi_miso),
        .door_unlock    (door_unlock),
        .status_unlock  (status_unlock),
        .status_fault   (status_fault),
        .status_busy    (status_busy),
        .start_auth_btn (start_auth_btn)
    );

    assign outs = {eeprom_spi_cs_n, nfc_spi_cs_n, eeprom_spi_sclk, nfc_spi_sclk,
                   eeprom_spi_mosi, nfc_spi_mosi, door_unlock, status_unlock,
                   status_fault, status_busy};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic fault;
        logic unlock;
    } verdict_t;

    int       ee_exp_q[$];
    int       nfc_exp_q[$];
    verdict_t verdict_q[$];

    logic [127:0] ee_key  = '0;
    logic [127:0] nfc_key = '0;
    int  nfc_mode = 0;
    int  ee_bits = 0, nfc_bits = 0, ee_bad = 0, nfc_bad = 0;
    int  ee_falls = 0, nfc_falls = 0, idle_err = 0, door_cnt = 0;
    int  ee_e, nfc_e;
    logic [7:0] ee_rx = '0, nfc_rx = '0;
    time ee_fall_t, ee_first_t, ee_last_t, ee_prev_t;
    time nfc_fall_t, nfc_first_t, nfc_last_t, nfc_prev_t;

    // EEPROM: opcode and address bytes, then the key MSB first; mode-0 slave.
    always_comb begin
        eeprom_spi_miso = 1'b0;
        if (!eeprom_spi_cs_n && ee_bits >= 16 && ee_bits < 144)
            eeprom_spi_miso = ee_key[7'(143 - ee_bits)];
    end

    // MFRC522: FIFO byte k is returned during transfer k+1.
    always_comb begin
        nfc_spi_miso = 1'b0;
        if (nfc_mode != 0 && !nfc_spi_cs_n && nfc_bits >= 8 && nfc_bits < 136)
            nfc_spi_miso = nfc_key[7'(135 - nfc_bits)];
    end

    always @(negedge eeprom_spi_cs_n) begin
        ee_bits = 0; ee_bad = 0; ee_fall_t = $time; ee_falls++;
    end
    always @(posedge eeprom_spi_sclk) if (!rst && !eeprom_spi_cs_n) begin
        if (ee_bits == 0) ee_first_t = $time;
        else if ($time - ee_prev_t != 40) ee_bad++;
        ee_prev_t = $time;
        ee_rx = {ee_rx[6:0], eeprom_spi_mosi};
    end
    always @(negedge eeprom_spi_sclk) if (!rst && !eeprom_spi_cs_n) begin
        ee_bits++;
        ee_last_t = $time;
        if (ee_bits % 8 == 0) begin
            if (ee_exp_q.size() > 0) ee_e = ee_exp_q.pop_front();
            else ee_e = -1;
            check("ee_mosi_byte", 64'(ee_rx), 64'(ee_e));
        end
    end
    always @(posedge eeprom_spi_cs_n) if (!rst) begin
        check("ee_bit_count", 64'(ee_bits), 64'd144);
        check("ee_sclk_period", 64'(ee_bad), 64'd0);
        check("ee_cs_lead", (ee_first_t - ee_fall_t) / 10, 64'(CLK_DIV));
        check("ee_cs_lag", ($time - ee_last_t) / 10, 64'(CLK_DIV));
    end

    always @(negedge nfc_spi_cs_n) begin
        nfc_bits = 0; nfc_bad = 0; nfc_fall_t = $time; nfc_falls++;
    end
    always @(posedge nfc_spi_sclk) if (!rst && !nfc_spi_cs_n) begin
        if (nfc_bits == 0) nfc_first_t = $time;
        else if ($time - nfc_prev_t != 40) nfc_bad++;
        nfc_prev_t = $time;
        nfc_rx = {nfc_rx[6:0], nfc_spi_mosi};
    end
    always @(negedge nfc_spi_sclk) if (!rst && !nfc_spi_cs_n) begin
        nfc_bits++;
        nfc_last_t = $time;
        if (nfc_bits % 8 == 0) begin
            if (nfc_exp_q.size() > 0) nfc_e = nfc_exp_q.pop_front();
            else nfc_e = -1;
            check("nfc_mosi_byte", 64'(nfc_rx), 64'(nfc_e));
        end
    end
    always @(posedge nfc_spi_cs_n) if (!rst) begin
        check("nfc_bit_count", 64'(nfc_bits), 64'd136);
        check("nfc_sclk_period", 64'(nfc_bad), 64'd0);
        check("nfc_cs_lead", (nfc_first_t - nfc_fall_t) / 10, 64'(CLK_DIV));
        check("nfc_cs_lag", ($time - nfc_last_t) / 10, 64'(CLK_DIV));
    end

    always @(negedge clk) if (!rst) begin
        if (eeprom_spi_cs_n && (eeprom_spi_sclk || eeprom_spi_mosi)) idle_err++;
        if (nfc_spi_cs_n && (nfc_spi_sclk || nfc_spi_mosi)) idle_err++;
        if (!eeprom_spi_cs_n && !nfc_spi_cs_n) idle_err++;
        if (door_unlock) door_cnt++;
    end

    task automatic pulse_start();
        @(negedge clk);
        start_auth_btn = 1'b1;
        repeat (2) @(negedge clk);
        start_auth_btn = 1'b0;
    endtask

    task automatic push_expect(input logic [127:0] key, input int mode, input logic [127:0] resp);
        logic     blank;
        verdict_t v;
        blank = (key == '0) || (key == '1);
        ee_key = key; nfc_key = resp; nfc_mode = mode;
        ee_exp_q.push_back(8'h03);
        ee_exp_q.push_back(8'h00);
        repeat (16) ee_exp_q.push_back(8'h00);
        if (!blank) begin
            repeat (16) nfc_exp_q.push_back(8'h92);
            nfc_exp_q.push_back(8'h00);
        end
        v.fault  = blank || (((mode == 0) ? 128'd0 : resp) != key);
        v.unlock = !v.fault;
        verdict_q.push_back(v);
    endtask

    task automatic run_auth(input string name, input logic [127:0] key, input int mode,
                            input logic [127:0] resp, input bit extra_pulse);
        verdict_t v;
        int       lat;
        logic     blank;
        blank = (key == '0) || (key == '1);
        ee_falls = 0; nfc_falls = 0; door_cnt = 0; idle_err = 0;
        push_expect(key, mode, resp);
        pulse_start();
        lat = 0;
        while (!status_busy && lat < 10) begin @(negedge clk); lat++; end
        check({name, ":busy_rise"}, 64'(status_busy), 64'd1);
        check({name, ":status_clear"}, {status_fault, status_unlock}, 64'd0);
        if (extra_pulse) begin
            repeat (300) @(negedge clk);
            check({name, ":busy_at_pulse"}, 64'(status_busy), 64'd1);
            pulse_start();
        end
        while (status_busy && lat < 5000) begin @(negedge clk); lat++; end
        check({name, ":settled"}, 64'(lat < 2000), 64'd1);
        if (verdict_q.size() > 0) v = verdict_q.pop_front();
        else begin v.fault = 1'bx; v.unlock = 1'bx; end
        check({name, ":fault"}, 64'(status_fault), 64'(v.fault));
        check({name, ":unlock"}, 64'(status_unlock), 64'(v.unlock));
        repeat (UNLOCK_CYCLES + 10) @(negedge clk);
        check({name, ":door_cycles"}, 64'(door_cnt), v.unlock ? 64'(UNLOCK_CYCLES) : 64'd0);
        check({name, ":held"}, {door_unlock, status_unlock, status_fault, status_busy},
              {1'b0, v.unlock, v.fault, 1'b0});
        check({name, ":ee_cs_count"}, 64'(ee_falls), 64'd1);
        check({name, ":nfc_cs_count"}, 64'(nfc_falls), blank ? 64'd0 : 64'd1);
        check({name, ":idle_bus"}, 64'(idle_err), 64'd0);
        check({name, ":ee_q_empty"}, 64'(ee_exp_q.size()), 64'd0);
        check({name, ":nfc_q_empty"}, 64'(nfc_exp_q.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs), 64'(RESET_OUTS));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_outputs", 64'(outs), 64'(RESET_OUTS));

        run_auth("nfc_zero",  PSK, 0, '0, 1'b0);
        run_auth("match",     PSK, 1, PSK, 1'b0);
        run_auth("last_byte", PSK, 1, {PSK[127:8], 8'h3d}, 1'b0);
        run_auth("blank_ff",  '1, 1, PSK, 1'b0);
        run_auth("busy_pulse", PSK, 1, PSK, 1'b1);
        run_auth("blank_00",  '0, 1, PSK, 1'b0);

        // Abort in the middle of the NFC burst.
        push_expect(PSK, 1, PSK);
        pulse_start();
        lat = 0;
        while (!(!nfc_spi_cs_n && nfc_bits >= 24) && lat < 3000) begin @(negedge clk); lat++; end
        check("rst_mid:in_nfc", 64'(nfc_spi_cs_n), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_mid:outputs", 64'(outs), 64'(RESET_OUTS));
        ee_exp_q.delete();
        nfc_exp_q.delete();
        verdict_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid:stays_idle", 64'(outs), 64'(RESET_OUTS));
        run_auth("after_rst", PSK, 1, PSK, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
